// File: rtl/xil_sync_width_fifo.sv
// xil_sync_width_fifo: single-clock FWFT FIFO with integer-ratio width conversion, flush, count, almost flags, over/underflow pulses
// Ports: axi_aclk/axi_resetn (async active-low) clock and reset; flush clears all state except storage;
//   wr_en/din write side with full/almost_full; rd_en/dout FWFT read side with empty/almost_empty;
//   count = storage entries held; overflow/underflow = one-cycle pulses for wr_en while full / rd_en while empty.
module xil_sync_width_fifo #(
  parameter int WR_DATA_WIDTH = 256,
  parameter int RD_DATA_WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int ALMOST_FULL_THRESH = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WR_DATA_WIDTH-1:0]   din,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [RD_DATA_WIDTH-1:0]   dout,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int W = WR_DATA_WIDTH > RD_DATA_WIDTH ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int N = WR_DATA_WIDTH < RD_DATA_WIDTH ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int R = W / N;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = R > 1 ? $clog2(R) : 1;
  localparam bit DOWN = WR_DATA_WIDTH >= RD_DATA_WIDTH;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  // Read lane when downsizing, assembly slot when upsizing.
  logic [LW-1:0] lane;
  logic last, wr_ok, rd_ok, commit, pop;
  assign last = lane == LW'(R - 1);
  assign empty = count == '0;
  // When upsizing only the committing write needs a free entry.
  assign full = count == (AW+1)'(DEPTH) && (DOWN || last);
  assign almost_full = 32'(count) >= ALMOST_FULL_THRESH;
  assign almost_empty = 32'(count) <= ALMOST_EMPTY_THRESH;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign commit = wr_ok && (DOWN || last);
  assign pop = rd_ok && (!DOWN || last);
  if (DOWN) begin : g_down
    assign entry = din;
    assign dout = empty ? '0 : mem[rd_ptr][W-1-lane*RD_DATA_WIDTH -: RD_DATA_WIDTH];
  end else begin : g_up
    // Holds the first R-1 narrow words; the R-th comes straight from din.
    logic [W-WR_DATA_WIDTH-1:0] asm_q;
    always_ff @(posedge axi_aclk)
      if (wr_ok && !last && !flush) asm_q[W-WR_DATA_WIDTH-1-lane*WR_DATA_WIDTH -: WR_DATA_WIDTH] <= din;
    assign entry = {asm_q, din};
    assign dout = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge axi_aclk)
    if (commit && !flush) mem[wr_ptr] <= entry;
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      lane <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      lane <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(commit);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(commit) - (AW+1)'(pop);
      if (DOWN ? rd_ok : wr_ok) lane <= last ? '0 : lane + 1'b1;
      overflow <= wr_en && full;
      underflow <= rd_en && empty;
    end
endmodule

// File: tb/tb_xil_sync_width_fifo.sv
// tb_xil_sync_width_fifo: self-checking bench for a 256->64 instance and a 64->256 DEPTH=2 instance
module tb_xil_sync_width_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic d_flush, d_wr, d_rd, d_full, d_af, d_empty, d_ae, d_ovf, d_unf;
  logic [255:0] d_din;
  logic [63:0] d_dout;
  logic [4:0] d_count;
  logic u_flush, u_wr, u_rd, u_full, u_af, u_empty, u_ae, u_ovf, u_unf;
  logic [63:0] u_din;
  logic [255:0] u_dout;
  logic [1:0] u_count;
  int errors = 0;
  int checks = 0;
  logic [63:0] q[$];
  typedef struct {
    logic wr;
    logic rd;
    logic [255:0] din;
    logic [63:0] dout;
    logic [4:0] cnt;
    logic emp;
  } vec_t;
  vec_t tv[5];
  xil_sync_width_fifo dut_d (
    .axi_aclk(clk), .axi_resetn(rst_n), .flush(d_flush), .wr_en(d_wr), .din(d_din),
    .full(d_full), .almost_full(d_af), .rd_en(d_rd), .dout(d_dout), .empty(d_empty),
    .almost_empty(d_ae), .count(d_count), .overflow(d_ovf), .underflow(d_unf)
  );
  xil_sync_width_fifo #(
    .WR_DATA_WIDTH(64), .RD_DATA_WIDTH(256), .DEPTH(2), .ALMOST_FULL_THRESH(2), .ALMOST_EMPTY_THRESH(0)
  ) dut_u (
    .axi_aclk(clk), .axi_resetn(rst_n), .flush(u_flush), .wr_en(u_wr), .din(u_din),
    .full(u_full), .almost_full(u_af), .rd_en(u_rd), .dout(u_dout), .empty(u_empty),
    .almost_empty(u_ae), .count(u_count), .overflow(u_ovf), .underflow(u_unf)
  );
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic d_step(input logic w, input logic r, input logic f, input logic [255:0] x);
    d_wr = w;
    d_rd = r;
    d_flush = f;
    d_din = x;
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    d_rd = 1'b0;
    d_flush = 1'b0;
  endtask
  task automatic u_step(input logic w, input logic r, input logic [63:0] x);
    u_wr = w;
    u_rd = r;
    u_din = x;
    @(posedge clk);
    #1;
    u_wr = 1'b0;
    u_rd = 1'b0;
  endtask
  function automatic logic [255:0] pat(input int b);
    return {64'(b), 64'(b + 1), 64'(b + 2), 64'(b + 3)};
  endfunction
  task automatic d_write(input logic [255:0] x);
    for (int k = 0; k < 4; k++) q.push_back(x[255-64*k -: 64]);
    d_step(1'b1, 1'b0, 1'b0, x);
  endtask
  task automatic d_read(input string nm);
    if (q.size() == 0) chk({nm, " scoreboard empty"}, 1'b1, 1'b0);
    else chk(nm, d_dout, q.pop_front());
    d_step(1'b0, 1'b1, 1'b0, '0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    {d_flush, d_wr, d_rd, u_flush, u_wr, u_rd} = '0;
    d_din = '0;
    u_din = '0;
    tv[0] = '{1'b1, 1'b0, {64'h3, 64'h2, 64'h1, 64'h0}, 64'h3, 5'd1, 1'b0};
    tv[1] = '{1'b0, 1'b1, 256'h0, 64'h2, 5'd1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 256'h0, 64'h1, 5'd1, 1'b0};
    tv[3] = '{1'b0, 1'b1, 256'h0, 64'h0, 5'd1, 1'b0};
    tv[4] = '{1'b0, 1'b1, 256'h0, 64'h0, 5'd0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst d_empty", d_empty, 1'b1);
    chk("rst d_ae", d_ae, 1'b1);
    chk("rst d_full", d_full, 1'b0);
    chk("rst d_af", d_af, 1'b0);
    chk("rst d_count", d_count, 0);
    chk("rst d_pulses", {d_ovf, d_unf}, 0);
    chk("rst d_dout", d_dout, 0);
    chk("rst u_empty", u_empty, 1'b1);
    chk("rst u_full", u_full, 1'b0);
    chk("rst u_count", u_count, 0);
    chk("rst u_dout", u_dout, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 1: one 256-bit word read as four lanes, MSB first
    for (int i = 0; i < 5; i++) begin
      d_step(tv[i].wr, tv[i].rd, 1'b0, tv[i].din);
      chk($sformatf("t1 dout[%0d]", i), d_dout, tv[i].dout);
      chk($sformatf("t1 count[%0d]", i), d_count, tv[i].cnt);
      chk($sformatf("t1 empty[%0d]", i), d_empty, tv[i].emp);
    end
    // 2: fill, overflow, drain in order, underflow
    for (int i = 0; i < 16; i++) begin
      d_write(pat(4 * i));
      chk($sformatf("t2 count[%0d]", i), d_count, i + 1);
      chk($sformatf("t2 af[%0d]", i), d_af, i + 1 >= 14);
      chk($sformatf("t2 full[%0d]", i), d_full, i + 1 == 16);
    end
    d_step(1'b1, 1'b0, 1'b0, '1);
    chk("t2 overflow", d_ovf, 1'b1);
    chk("t2 count after overflow", d_count, 16);
    d_step(1'b0, 1'b0, 1'b0, '0);
    chk("t2 overflow cleared", d_ovf, 1'b0);
    for (int i = 0; i < 64; i++) d_read($sformatf("t2 read[%0d]", i));
    chk("t2 drained empty", d_empty, 1'b1);
    d_step(1'b0, 1'b1, 1'b0, '0);
    chk("t2 underflow", d_unf, 1'b1);
    chk("t2 count after underflow", d_count, 0);
    d_step(1'b0, 1'b0, 1'b0, '0);
    chk("t2 underflow cleared", d_unf, 1'b0);
    // 5: flush with count=5, lane=2, alongside wr_en and rd_en
    for (int i = 0; i < 5; i++) d_write(pat(100 + 4 * i));
    d_read("t5 pre read0");
    d_read("t5 pre read1");
    chk("t5 count before flush", d_count, 5);
    d_step(1'b1, 1'b1, 1'b1, pat(900));
    chk("t5 flush count", d_count, 0);
    chk("t5 flush empty", d_empty, 1'b1);
    chk("t5 flush pulses", {d_ovf, d_unf}, 0);
    q.delete();
    d_write(pat(500));
    for (int i = 0; i < 4; i++) d_read($sformatf("t5 post read[%0d]", i));
    chk("t5 post empty", d_empty, 1'b1);
    // 6: asynchronous reset mid-read, then pointer wrap
    for (int i = 0; i < 3; i++) d_write(pat(200 + 4 * i));
    d_read("t6 pre read");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async count", d_count, 0);
    chk("t6 async empty", d_empty, 1'b1);
    chk("t6 async dout", d_dout, 0);
    chk("t6 async flags", {d_full, d_af, d_ae, d_ovf, d_unf}, 5'b00100);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      d_write(pat(1000 + 4 * i));
      for (int k = 0; k < 4; k++) d_read($sformatf("t6 wrap[%0d.%0d]", i, k));
    end
    chk("t6 final empty", d_empty, 1'b1);
    chk("t6 final count", d_count, 0);
    // 3: upsizing assembly
    u_step(1'b1, 1'b0, 64'hA);
    chk("t3 empty after A", u_empty, 1'b1);
    u_step(1'b1, 1'b0, 64'hB);
    chk("t3 empty after B", u_empty, 1'b1);
    u_step(1'b1, 1'b0, 64'hC);
    chk("t3 empty after C", u_empty, 1'b1);
    u_step(1'b1, 1'b0, 64'hD);
    chk("t3 empty after D", u_empty, 1'b0);
    chk("t3 dout", u_dout, {64'hA, 64'hB, 64'hC, 64'hD});
    chk("t3 count", u_count, 1);
    // 4: full with a pending completing write
    for (int i = 0; i < 4; i++) u_step(1'b1, 1'b0, 64'hE + 64'(i));
    chk("t4 count full storage", u_count, 2);
    chk("t4 af", u_af, 1'b1);
    chk("t4 not full at slot0", u_full, 1'b0);
    for (int i = 0; i < 3; i++) u_step(1'b1, 1'b0, 64'h12 + 64'(i));
    chk("t4 full", u_full, 1'b1);
    u_step(1'b1, 1'b1, 64'h15);
    chk("t4 overflow", u_ovf, 1'b1);
    chk("t4 count", u_count, 1);
    chk("t4 head", u_dout, {64'hE, 64'hF, 64'h10, 64'h11});
    u_step(1'b1, 1'b0, 64'h15);
    chk("t4 commit count", u_count, 2);
    chk("t4 overflow cleared", u_ovf, 1'b0);
    u_step(1'b0, 1'b1, '0);
    chk("t4 next head", u_dout, {64'h12, 64'h13, 64'h14, 64'h15});
    u_step(1'b0, 1'b1, '0);
    chk("t4 empty", u_empty, 1'b1);
    u_step(1'b0, 1'b1, '0);
    chk("t4 underflow", u_unf, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
